// File: rtl/sad_pkg.sv
// Shared constants and state encoding for the SAD block loader.
package sad_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int BLK_DIM    = 16;
  localparam int BLK_PIX    = BLK_DIM * BLK_DIM;
  localparam int ROW_W      = BLK_DIM * DWIDTH_DEF;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Width of one packed block row for a given pixel width.
  function automatic int row_w(input int dw);
    return BLK_DIM * dw;
  endfunction

endpackage

// File: rtl/sad_row_store.sv
// 16-row block register array: one row written per cycle, whole block visible.
module sad_row_store
  import sad_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          clr_n_i,
  input  logic                          we_i,
  input  logic [3:0]                    widx_i,
  input  logic [row_w(DWIDTH)-1:0]      wdata_i,
  output logic [BLK_PIX*DWIDTH-1:0]     blk_o
);

  localparam int RW = row_w(DWIDTH);

  logic [RW-1:0] rows_q [BLK_DIM];

  // Row storage: synchronous clear, otherwise write the addressed row only.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int r = 0; r < BLK_DIM; r++) rows_q[r] <= '0;
    end else if (we_i) begin
      rows_q[widx_i] <= wdata_i;
    end
  end

  // Row r occupies pixels r*16 .. r*16+15 of the flat block.
  for (genvar g = 0; g < BLK_DIM; g++) begin : g_pack
    assign blk_o[g*RW +: RW] = rows_q[g];
  end

endmodule

// File: rtl/sad_blk_loader.sv
// Assembles 16 row beats into a 16x16 current/reference block pair and
// pulses cal_en for one cycle when a complete block is presented.
module sad_blk_loader
  import sad_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          row_vld,
  output logic                          row_rdy,
  input  logic                          row_sop,
  input  logic [row_w(DWIDTH)-1:0]      cur_row,
  input  logic [row_w(DWIDTH)-1:0]      ref_row,
  input  logic                          flush,
  output logic [BLK_PIX*DWIDTH-1:0]     din,
  output logic [BLK_PIX*DWIDTH-1:0]     refi,
  output logic                          cal_en,
  output logic [7:0]                    blk_cnt,
  output logic                          sop_err
);

  state_e     state_q, state_d;
  logic [3:0] row_cnt_q, row_cnt_d;
  logic [7:0] blk_cnt_q, blk_cnt_d;
  logic       sop_err_q, sop_err_d;

  logic       accept;
  logic       beat_ok;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic       last_row;

  // A flushed beat is still consumed, it just has no effect on the block.
  assign accept   = row_vld & row_rdy;
  assign beat_ok  = accept & ~flush;
  // A non-sop beat with row_cnt=0 has no block to belong to and is dropped.
  assign wr_en    = beat_ok & (row_sop | (row_cnt_q != 4'd0));
  assign wr_idx   = row_sop ? 4'd0 : row_cnt_q;
  assign last_row = beat_ok & ~row_sop & (row_cnt_q == 4'd15);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  // FSM next state: ISSUE lasts exactly one cycle after row 15 lands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:  if (last_row) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  // FSM outputs; both forced low while reset is held.
  always_comb begin
    row_rdy = 1'b0;
    cal_en  = 1'b0;
    if (rstn) begin
      row_rdy = (state_q == ST_FILL);
      cal_en  = (state_q == ST_ISSUE);
    end
  end

  // Row counter, block counter and framing-error next state.
  always_comb begin
    row_cnt_d = row_cnt_q;
    if (flush) begin
      row_cnt_d = 4'd0;
    end else if (accept) begin
      if (row_sop)                  row_cnt_d = 4'd1;
      else if (row_cnt_q != 4'd0)   row_cnt_d = row_cnt_q + 4'd1;
    end
    sop_err_d = beat_ok & (row_sop ? (row_cnt_q != 4'd0) : (row_cnt_q == 4'd0));
    blk_cnt_d = blk_cnt_q + (last_row ? 8'd1 : 8'd0);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_cnt_q <= 4'd0;
      blk_cnt_q <= 8'd0;
      sop_err_q <= 1'b0;
    end else begin
      row_cnt_q <= row_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      sop_err_q <= sop_err_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
  assign sop_err = sop_err_q;

  sad_row_store #(.DWIDTH(DWIDTH)) u_cur_store (
    .clk_i   (clk),
    .clr_n_i (rstn),
    .we_i    (wr_en),
    .widx_i  (wr_idx),
    .wdata_i (cur_row),
    .blk_o   (din)
  );

  sad_row_store #(.DWIDTH(DWIDTH)) u_ref_store (
    .clk_i   (clk),
    .clr_n_i (rstn),
    .we_i    (wr_en),
    .widx_i  (wr_idx),
    .wdata_i (ref_row),
    .blk_o   (refi)
  );

endmodule

// File: tb/tb_sad_blk_loader.sv
// Scoreboard bench for sad_blk_loader: expected blocks are queued as rows
// are driven and compared whenever cal_en fires.
module tb_sad_blk_loader;

  localparam int DW = 8;
  localparam int RW = 16 * DW;
  localparam int BW = 256 * DW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          row_vld;
  logic          row_rdy;
  logic          row_sop;
  logic [RW-1:0] cur_row;
  logic [RW-1:0] ref_row;
  logic          flush;
  logic [BW-1:0] din;
  logic [BW-1:0] refi;
  logic          cal_en;
  logic [7:0]    blk_cnt;
  logic          sop_err;

  always #5 clk = ~clk;

  sad_blk_loader #(.DWIDTH(DW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .row_vld (row_vld),
    .row_rdy (row_rdy),
    .row_sop (row_sop),
    .cur_row (cur_row),
    .ref_row (ref_row),
    .flush   (flush),
    .din     (din),
    .refi    (refi),
    .cal_en  (cal_en),
    .blk_cnt (blk_cnt),
    .sop_err (sop_err)
  );

  typedef struct {
    logic [BW-1:0] d;
    logic [BW-1:0] r;
    logic [7:0]    cnt;
  } exp_t;

  exp_t          sb[$];
  int            cal_cyc[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            sop_seen = 0;
  int            rdy_viol = 0;
  logic [BW-1:0] last_d;
  logic [BW-1:0] last_r;
  logic [7:0]    exp_cnt;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] fold(input logic [BW-1:0] b);
    logic [63:0] h;
    h = '0;
    for (int k = 0; k < BW / 64; k++) h = {h[62:0], h[63]} ^ b[k*64 +: 64];
    return h;
  endfunction

  function automatic logic [RW-1:0] mk_cur(input int s, input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < 16; c++) v[c*DW +: DW] = 8'((s + r * 16 + c) & 255);
    return v;
  endfunction

  function automatic logic [RW-1:0] mk_ref(input int s, input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < 16; c++) v[c*DW +: DW] = (s == 0) ? 8'd0 : 8'((s * 5 + r * 3 + c * 11) & 255);
    return v;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: scoreboard pop on cal_en, pulse counting, ready/issue relation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && row_rdy === cal_en) rdy_viol++;
    if (sop_err === 1'b1) sop_seen++;
    if (cal_en === 1'b1) begin : pop_blk
      exp_t e;
      cal_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check_val("unexpected_cal_en", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_val("din", fold(din), fold(e.d));
        check_val("refi", fold(refi), fold(e.r));
        check_val("blk_cnt", {56'd0, blk_cnt}, {56'd0, e.cnt});
      end
    end
  end

  task automatic beat(input logic sop, input logic [RW-1:0] cr, input logic [RW-1:0] rr,
                      input logic fl);
    int w;
    w = 0;
    @(negedge clk);
    row_vld = 1'b1;
    row_sop = sop;
    cur_row = cr;
    ref_row = rr;
    flush   = fl;
    while (row_rdy !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) check_val("rdy_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    row_vld = 1'b0;
    row_sop = 1'b0;
    flush   = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_block(input int cs, input int rs, input bit push);
    logic [BW-1:0] bd;
    logic [BW-1:0] br;
    for (int i = 0; i < 16; i++) begin
      beat(i == 0, mk_cur(cs, i), mk_ref(rs, i), 1'b0);
      bd[i*RW +: RW] = mk_cur(cs, i);
      br[i*RW +: RW] = mk_ref(rs, i);
    end
    if (push) begin
      exp_cnt = exp_cnt + 8'd1;
      sb.push_back('{bd, br, exp_cnt});
      last_d = bd;
      last_r = br;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    row_vld = 1'b0;
    flush   = 1'b0;
    rstn    = 1'b0;
    repeat (2) @(negedge clk);
    rstn    = 1'b1;
    exp_cnt = 8'd0;
    last_d  = '0;
    last_r  = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int sad;
    int a;
    int b;
    rstn    = 1'b0;
    row_vld = 1'b0;
    row_sop = 1'b0;
    flush   = 1'b0;
    cur_row = '0;
    ref_row = '0;
    exp_cnt = 8'd0;
    last_d  = '0;
    last_r  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_row_rdy", {63'd0, row_rdy}, 64'd0);
    check_val("rst_cal_en", {63'd0, cal_en}, 64'd0);
    check_val("rst_sop_err", {63'd0, sop_err}, 64'd0);
    check_val("rst_blk_cnt", {56'd0, blk_cnt}, 64'd0);
    check_val("rst_din", fold(din), 64'd0);
    check_val("rst_refi", fold(refi), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_val("fill_row_rdy", {63'd0, row_rdy}, 64'd1);

    // Ramp block, zero reference: SAD equals sum of 0..255.
    send_block(0, 0, 1'b1);
    #1;
    check_val("cal_latency", {63'd0, cal_en}, 64'd1);
    sad = 0;
    for (int i = 0; i < 256; i++) begin
      a = int'(din[i*DW +: DW]);
      b = int'(refi[i*DW +: DW]);
      sad += (a > b) ? (a - b) : (b - a);
    end
    check_val("sad", 64'(sad), 64'd32640);
    check_val("blk_cnt_first", {56'd0, blk_cnt}, 64'd1);
    idle(3);
    check_val("cal_one_cycle", {63'd0, cal_en}, 64'd0);
    check_val("din_hold", fold(din), fold(last_d));

    // Three blocks back to back with row_vld held.
    do_reset();
    cal_cyc.delete();
    rdy_viol = 0;
    for (int k = 0; k < 3; k++) send_block(100 + k, 50 + k, 1'b1);
    idle(3);
    check_val("b2b_cal_count", 64'(cal_cyc.size()), 64'd3);
    if (cal_cyc.size() >= 3) begin
      check_val("b2b_space1", 64'(cal_cyc[1] - cal_cyc[0]), 64'd17);
      check_val("b2b_space2", 64'(cal_cyc[2] - cal_cyc[1]), 64'd17);
    end
    check_val("b2b_blk_cnt", {56'd0, blk_cnt}, 64'd3);
    check_val("b2b_rdy_issue", 64'(rdy_viol), 64'd0);

    // Orphan row 0 without sop: dropped with a framing error.
    base = sop_seen;
    beat(1'b0, mk_cur(200, 0), mk_ref(201, 0), 1'b0);
    #1;
    check_val("nosop_err", {63'd0, sop_err}, 64'd1);
    check_val("nosop_nowrite", fold(din), fold(last_d));
    idle(2);
    send_block(60, 61, 1'b1);
    idle(3);
    check_val("nosop_err_cnt", 64'(sop_seen - base), 64'd1);

    // sop in the middle of a block restarts it.
    base = sop_seen;
    for (int i = 0; i < 7; i++) beat(i == 0, mk_cur(70, i), mk_ref(71, i), 1'b0);
    send_block(80, 81, 1'b1);
    idle(3);
    check_val("midsop_err_cnt", 64'(sop_seen - base), 64'd1);

    // Flush at row 10, then flush together with sop.
    base = sop_seen;
    for (int i = 0; i < 10; i++) beat(i == 0, mk_cur(90, i), mk_ref(91, i), 1'b0);
    beat(1'b0, mk_cur(90, 10), mk_ref(91, 10), 1'b1);
    #1;
    check_val("flush_no_err", {63'd0, sop_err}, 64'd0);
    check_val("flush_nowrite", din[10*RW +: 64], last_d[10*RW +: 64]);
    beat(1'b1, mk_cur(95, 0), mk_ref(96, 0), 1'b1);
    #1;
    check_val("flush_sop_no_err", {63'd0, sop_err}, 64'd0);
    beat(1'b0, mk_cur(97, 1), mk_ref(98, 1), 1'b0);
    #1;
    check_val("flush_cleared_cnt", {63'd0, sop_err}, 64'd1);
    idle(2);
    send_block(110, 111, 1'b1);
    idle(3);
    check_val("flush_err_cnt", 64'(sop_seen - base), 64'd1);

    // Reset at row 10 aborts the block and clears the outputs.
    for (int i = 0; i < 10; i++) beat(i == 0, mk_cur(120, i), mk_ref(121, i), 1'b0);
    @(negedge clk);
    row_vld = 1'b0;
    rstn    = 1'b0;
    repeat (2) @(negedge clk);
    check_val("midrst_row_rdy", {63'd0, row_rdy}, 64'd0);
    check_val("midrst_cal_en", {63'd0, cal_en}, 64'd0);
    check_val("midrst_blk_cnt", {56'd0, blk_cnt}, 64'd0);
    check_val("midrst_din", fold(din), 64'd0);
    check_val("midrst_refi", fold(refi), 64'd0);
    rstn    = 1'b1;
    exp_cnt = 8'd0;
    last_d  = '0;
    last_r  = '0;
    send_block(130, 131, 1'b1);
    idle(3);
    check_val("midrst_next_cnt", {56'd0, blk_cnt}, 64'd1);

    // 256 blocks: counter wraps to 0 on the last one.
    do_reset();
    cal_cyc.delete();
    for (int k = 0; k < 256; k++) send_block(k * 3, k * 7 + 1, 1'b1);
    idle(3);
    check_val("wrap_cal_count", 64'(cal_cyc.size()), 64'd256);
    check_val("wrap_blk_cnt", {56'd0, blk_cnt}, 64'd0);

    check_val("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
